// File: rtl/eflags_pkg.sv
// -----------------------------------------------------------------------------
// eflags_pkg
// Shared definitions for the EFLAGS write-back block:
//   - ALU1/CMPS flag-vector indices (CF_IDX..OF_IDX)
//   - architectural EFLAGS bit positions (CF_BIT..OF_BIT)
//   - ISR tracking state type
//   - one-entry EX->WB latch payload
// -----------------------------------------------------------------------------
package eflags_pkg;

  // Index of each flag inside the 6-bit ALU1/CMPS flag vectors.
  localparam int CF_IDX = 0;
  localparam int PF_IDX = 1;
  localparam int AF_IDX = 2;
  localparam int ZF_IDX = 3;
  localparam int SF_IDX = 4;
  localparam int OF_IDX = 5;

  // Position of each flag inside the 32-bit EFLAGS register.
  localparam int CF_BIT = 0;
  localparam int PF_BIT = 2;
  localparam int AF_BIT = 4;
  localparam int ZF_BIT = 6;
  localparam int SF_BIT = 7;
  localparam int DF_BIT = 10;
  localparam int OF_BIT = 11;

  // Bit 1 of EFLAGS is hard-wired to one.
  localparam logic [31:0] EFLAGS_FIXED1 = 32'h0000_0002;

  typedef enum logic {
    IDLE = 1'b0,
    ISR  = 1'b1
  } isr_state_t;

  typedef struct packed {
    logic        v;         // entry holds a flag-producing op
    logic [5:0]  flags;     // selected ALU1/CMPS flags
    logic [5:0]  ld;        // per-flag load enables, flag-vector indexing
    logic        ld_df;
    logic        df_val;
    logic        popf_v;    // full EFLAGS load, overrides ld/ld_df
    logic [31:0] popf_val;
  } wb_entry_t;

  // Map a flag-vector index to its EFLAGS bit position.
  function automatic int flag_bit(input int idx);
    case (idx)
      CF_IDX:  return CF_BIT;
      PF_IDX:  return PF_BIT;
      AF_IDX:  return AF_BIT;
      ZF_IDX:  return ZF_BIT;
      SF_IDX:  return SF_BIT;
      default: return OF_BIT;
    endcase
  endfunction

endpackage

// File: rtl/eflags_merge.sv
// -----------------------------------------------------------------------------
// eflags_merge
// Combinational merge of a 6-bit flag vector into a 32-bit EFLAGS value.
// Only flags whose mask bit is set replace the base value; DF is replaced when
// i_ld_df is set. Bit 1 of the result is always one.
// Ports:
//   i_base    [31:0]  current EFLAGS value
//   i_flags   [5:0]   new flag values (CF0 PF1 AF2 ZF3 SF4 OF5)
//   i_mask    [5:0]   per-flag load enables, same indexing
//   i_ld_df           load DF
//   i_df_val          new DF value
//   o_eflags  [31:0]  merged EFLAGS
// -----------------------------------------------------------------------------
module eflags_merge
  import eflags_pkg::*;
(
  input  logic [31:0] i_base,
  input  logic [5:0]  i_flags,
  input  logic [5:0]  i_mask,
  input  logic        i_ld_df,
  input  logic        i_df_val,
  output logic [31:0] o_eflags
);

  always_comb begin
    // NOTE: assigning a full default first keeps this block free of inferred
    // latches even though the loop only touches a few bits.
    o_eflags = i_base;
    for (int i = 0; i < 6; i++) begin
      if (i_mask[i]) o_eflags[flag_bit(i)] = i_flags[i];
    end
    if (i_ld_df) o_eflags[DF_BIT] = i_df_val;
    o_eflags = o_eflags | EFLAGS_FIXED1;
  end

endmodule

// File: rtl/eflags_wb.sv
// -----------------------------------------------------------------------------
// eflags_wb
// Consumer end of the ALU1 flag interface. Latches ALU1/CMPS flag results into
// a one-entry EX->WB register, commits them to the architectural EFLAGS, feeds
// CF/AF/DF back to ALU1 and saves/restores EFLAGS around an ISR.
//
// Build option: define EFLAGS_BYPASS_EN to forward the pending WB entry to
// CF_in/AF_in/DF_in (ex_stall tied low). Without it, EX is stalled while the
// pending entry writes CF, AF, DF or is a POPF.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ex_v                           EX holds a valid flag-producing op
//   alu1_flags, cmps_flags [5:0]   flag sources; cmps_sel picks cmps_flags
//   ld_flag_CF..ld_flag_OF         per-flag load enables
//   df_val_ex, ld_df               DF update
//   popf_v, popf_val [31:0]        full EFLAGS load
//   wb_stall, flush                WB hold / kill pending entry
//   isr_entry, iret                interrupt entry / return pulses
//   eflags [31:0]                  architectural EFLAGS
//   CF_in, AF_in, DF_in            flags returned to ALU1
//   ex_stall                       EX must hold this cycle
//   isr_active, isr_err            ISR state, sticky protocol error
// -----------------------------------------------------------------------------
module eflags_wb
  import eflags_pkg::*;
#(
  parameter logic [31:0] RST_EFLAGS = 32'h0000_0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_v,
  input  logic [5:0]  alu1_flags,
  input  logic [5:0]  cmps_flags,
  input  logic        cmps_sel,
  input  logic        ld_flag_CF,
  input  logic        ld_flag_PF,
  input  logic        ld_flag_AF,
  input  logic        ld_flag_ZF,
  input  logic        ld_flag_SF,
  input  logic        ld_flag_OF,
  input  logic        df_val_ex,
  input  logic        ld_df,
  input  logic        popf_v,
  input  logic [31:0] popf_val,
  input  logic        wb_stall,
  input  logic        flush,
  input  logic        isr_entry,
  input  logic        iret,
  output logic [31:0] eflags,
  output logic        CF_in,
  output logic        AF_in,
  output logic        DF_in,
  output logic        ex_stall,
  output logic        isr_active,
  output logic        isr_err
);

  wb_entry_t   r_wb;
  wb_entry_t   w_ex_entry;
  isr_state_t  r_state;
  logic [31:0] r_eflags;
  logic [31:0] r_saved_eflags;
  logic        r_isr_err;

  logic [31:0] w_merged;
  logic [31:0] w_wb_eflags;     // EFLAGS as the pending entry would leave it
  logic [31:0] w_after_commit;  // EFLAGS after this cycle's commit, if any
  logic [31:0] w_fwd;
  logic        w_commit;

  always_comb begin
    w_ex_entry          = '0;
    w_ex_entry.v        = ex_v;
    w_ex_entry.flags    = cmps_sel ? cmps_flags : alu1_flags;
    w_ex_entry.ld       = {ld_flag_OF, ld_flag_SF, ld_flag_ZF,
                           ld_flag_AF, ld_flag_PF, ld_flag_CF};
    w_ex_entry.ld_df    = ld_df;
    w_ex_entry.df_val   = df_val_ex;
    w_ex_entry.popf_v   = popf_v;
    w_ex_entry.popf_val = popf_val;
  end

  // One merge serves both the commit path and the forwarding path.
  eflags_merge u_merge (
    .i_base   (r_eflags),
    .i_flags  (r_wb.flags),
    .i_mask   (r_wb.ld),
    .i_ld_df  (r_wb.ld_df),
    .i_df_val (r_wb.df_val),
    .o_eflags (w_merged)
  );

  assign w_wb_eflags    = r_wb.popf_v ? (r_wb.popf_val | EFLAGS_FIXED1) : w_merged;
  assign w_commit       = r_wb.v & ~wb_stall & ~flush;
  assign w_after_commit = w_commit ? w_wb_eflags : r_eflags;

`ifdef EFLAGS_BYPASS_EN
  assign w_fwd    = r_wb.v ? w_wb_eflags : r_eflags;
  assign ex_stall = 1'b0;
`else
  assign w_fwd    = r_eflags;
  assign ex_stall = ex_v & r_wb.v &
                    (r_wb.ld[CF_IDX] | r_wb.ld[AF_IDX] | r_wb.ld_df | r_wb.popf_v);
`endif

  assign CF_in      = w_fwd[CF_BIT];
  assign AF_in      = w_fwd[AF_BIT];
  assign DF_in      = w_fwd[DF_BIT];
  assign eflags     = r_eflags;
  assign isr_active = (r_state == ISR);
  assign isr_err    = r_isr_err;

  // EX->WB latch. A stalled EX inserts a bubble so the entry that commits this
  // cycle is not left behind to commit a second time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb <= '0;
    end else if (flush) begin
      r_wb.v <= 1'b0;
    end else if (!wb_stall) begin
      if (ex_stall) r_wb.v <= 1'b0;
      else          r_wb   <= w_ex_entry;
    end
  end

  // Architectural EFLAGS and ISR tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eflags       <= RST_EFLAGS | EFLAGS_FIXED1;
      r_saved_eflags <= '0;
      r_state        <= IDLE;
      r_isr_err      <= 1'b0;
    end else begin
      r_eflags <= w_after_commit;
      case (r_state)
        IDLE: begin
          if (isr_entry) begin
            r_saved_eflags <= w_after_commit;
            r_state        <= ISR;
          end
          if (iret) r_isr_err <= 1'b1;
        end
        ISR: begin
          if (iret) begin
            // NOTE: this later non-blocking write to r_eflags wins over the
            // commit value above, which is how a restore overrides a commit.
            r_eflags <= r_saved_eflags;
            r_state  <= IDLE;
          end
          if (isr_entry) r_isr_err <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eflags_wb.sv
// -----------------------------------------------------------------------------
// tb_eflags_wb
// Directed and randomized stimulus for eflags_wb, compared every cycle against
// a transaction-level reference model of the flag pipeline and ISR tracking.
// -----------------------------------------------------------------------------
module tb_eflags_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_v;
  logic [5:0]  alu1_flags, cmps_flags;
  logic        cmps_sel;
  logic        ld_flag_CF, ld_flag_PF, ld_flag_AF, ld_flag_ZF, ld_flag_SF, ld_flag_OF;
  logic        df_val_ex, ld_df, popf_v;
  logic [31:0] popf_val;
  logic        wb_stall, flush, isr_entry, iret;
  logic [31:0] eflags;
  logic        CF_in, AF_in, DF_in, ex_stall, isr_active, isr_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  eflags_wb #(.RST_EFLAGS(32'h0)) dut (
    .clk(clk), .rst(rst), .ex_v(ex_v),
    .alu1_flags(alu1_flags), .cmps_flags(cmps_flags), .cmps_sel(cmps_sel),
    .ld_flag_CF(ld_flag_CF), .ld_flag_PF(ld_flag_PF), .ld_flag_AF(ld_flag_AF),
    .ld_flag_ZF(ld_flag_ZF), .ld_flag_SF(ld_flag_SF), .ld_flag_OF(ld_flag_OF),
    .df_val_ex(df_val_ex), .ld_df(ld_df), .popf_v(popf_v), .popf_val(popf_val),
    .wb_stall(wb_stall), .flush(flush), .isr_entry(isr_entry), .iret(iret),
    .eflags(eflags), .CF_in(CF_in), .AF_in(AF_in), .DF_in(DF_in),
    .ex_stall(ex_stall), .isr_active(isr_active), .isr_err(isr_err)
  );

  // ---------------- reference model state ----------------
  logic [31:0] m_eflags, m_saved;
  logic        m_isr, m_err;
  logic        m_pv;                     // an op is waiting to be committed
  logic [5:0]  m_pflags, m_pld;
  logic        m_pldf, m_pdf, m_ppv;
  logic [31:0] m_ppval;

  // EFLAGS position of each flag in the 6-bit flag vector.
  localparam int POS [6] = '{0, 2, 4, 6, 7, 11};

  // Result of writing an op's flags onto a base EFLAGS value.
  function automatic logic [31:0] m_apply(input logic [31:0] base);
    logic [31:0] r;
    if (m_ppv) return m_ppval | 32'h2;
    r = base;
    for (int i = 0; i < 6; i++)
      if (m_pld[i]) r[POS[i]] = m_pflags[i];
    if (m_pldf) r[10] = m_pdf;
    return r | 32'h2;
  endfunction

  function automatic logic [31:0] m_fwd();
`ifdef EFLAGS_BYPASS_EN
    return m_pv ? m_apply(m_eflags) : m_eflags;
`else
    return m_eflags;
`endif
  endfunction

  function automatic logic m_stall();
`ifdef EFLAGS_BYPASS_EN
    return 1'b0;
`else
    return ex_v && m_pv && (m_pld[0] || m_pld[2] || m_pldf || m_ppv);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rst = 0; ex_v = 0; alu1_flags = '0; cmps_flags = '0; cmps_sel = 0;
    {ld_flag_OF, ld_flag_SF, ld_flag_ZF, ld_flag_AF, ld_flag_PF, ld_flag_CF} = '0;
    df_val_ex = 0; ld_df = 0; popf_v = 0; popf_val = '0;
    wb_stall = 0; flush = 0; isr_entry = 0; iret = 0;
  endtask

  task automatic drive_op(input logic [5:0] flags, input logic [5:0] ld);
    set_idle();
    ex_v = 1; alu1_flags = flags;
    {ld_flag_OF, ld_flag_SF, ld_flag_ZF, ld_flag_AF, ld_flag_PF, ld_flag_CF} = ld;
  endtask

  task automatic drive_popf(input logic [31:0] val);
    set_idle();
    ex_v = 1; popf_v = 1; popf_val = val;
  endtask

  // Inputs are driven at posedge+1. Combinational outputs are checked at
  // posedge+2, the model advances across the edge, registers checked after.
  task automatic cycle();
    logic [31:0] after, n_eflags, n_saved;
    logic        n_isr, n_err, commit, stall;
    logic [31:0] f;
    #1;
    f = m_fwd();
    check("CF_in",    32'(CF_in),    32'(f[0]));
    check("AF_in",    32'(AF_in),    32'(f[4]));
    check("DF_in",    32'(DF_in),    32'(f[10]));
    check("ex_stall", 32'(ex_stall), 32'(m_stall()));
    stall = m_stall();
    commit = m_pv && !wb_stall && !flush;
    after = commit ? m_apply(m_eflags) : m_eflags;
    n_eflags = after; n_saved = m_saved; n_isr = m_isr; n_err = m_err;
    if (!m_isr) begin
      if (isr_entry) begin n_saved = after; n_isr = 1; end
      if (iret) n_err = 1;
    end else begin
      if (iret) begin n_eflags = m_saved; n_isr = 0; end
      if (isr_entry) n_err = 1;
    end
    @(posedge clk);
    if (rst) begin
      m_eflags = 32'h2; m_saved = '0; m_isr = 0; m_err = 0; m_pv = 0;
    end else begin
      m_eflags = n_eflags; m_saved = n_saved; m_isr = n_isr; m_err = n_err;
      if (flush)          m_pv = 0;
      else if (wb_stall)  ;
      else if (stall)     m_pv = 0;
      else begin
        m_pv = ex_v; m_pflags = cmps_sel ? cmps_flags : alu1_flags;
        m_pld = {ld_flag_OF, ld_flag_SF, ld_flag_ZF, ld_flag_AF, ld_flag_PF, ld_flag_CF};
        m_pldf = ld_df; m_pdf = df_val_ex; m_ppv = popf_v; m_ppval = popf_val;
      end
    end
    #1;
    check("eflags",     eflags,            m_eflags);
    check("isr_active", 32'(isr_active),   32'(m_isr));
    check("isr_err",    32'(isr_err),      32'(m_err));
  endtask

  initial begin
    set_idle();
    m_pflags = '0; m_pld = '0; m_pldf = 0; m_pdf = 0; m_ppv = 0; m_ppval = '0;
    @(posedge clk); #1;

    // Reset state
    rst = 1; cycle(); cycle();
    check("rst_eflags", eflags, 32'h2);
    check("rst_cf_af_df", {29'b0, CF_in, AF_in, DF_in}, 32'h0);
    check("rst_isr", {30'b0, isr_active, isr_err}, 32'h0);

    // Basic op: visible two edges after EX
    drive_op(6'b011001, 6'b111111); cycle();
    set_idle(); cycle();
    check("basic_c3", eflags, 32'h0000_00C3);

    // Clear flags, then CF-only op followed by a dependent op
    drive_op(6'b000000, 6'b111111); cycle();
    set_idle(); cycle();
    drive_op(6'b000001, 6'b000001); cycle();
    drive_op(6'b000000, 6'b001000); #1;
`ifdef EFLAGS_BYPASS_EN
    check("byp_cf_in", 32'(CF_in), 32'h1);
    check("byp_eflags_cf", 32'(eflags[0]), 32'h0);
`else
    check("stall_hi", 32'(ex_stall), 32'h1);
`endif
    cycle();
`ifndef EFLAGS_BYPASS_EN
    #1 check("stall_lo", 32'(ex_stall), 32'h0);
    cycle();
`endif
    set_idle(); cycle(); cycle();
    check("cf_set", eflags, 32'h0000_0003);

    // WB stall for three cycles, then release commits once
    drive_op(6'b001000, 6'b001000); cycle();
    set_idle(); wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_hold", eflags, 32'h0000_0003);
    end
    wb_stall = 0; cycle();
    check("stall_commit", eflags, 32'h0000_0043);

    // Flush during stall drops the entry
    drive_op(6'b000000, 6'b111111); cycle();
    set_idle(); wb_stall = 1; cycle();
    flush = 1; cycle();
    set_idle(); cycle(); cycle();
    check("flush_nocommit", eflags, 32'h0000_0043);

    // POPF
    drive_popf(32'h0000_0C15); cycle();
    set_idle(); cycle();
    check("popf", eflags, 32'h0000_0C17);
    check("popf_df", 32'(DF_in), 32'h1);

    // ISR save / restore
    drive_popf(32'h0000_0001); cycle();
    set_idle(); cycle();
    isr_entry = 1; cycle();
    set_idle();
    check("isr_on", 32'(isr_active), 32'h1);
    drive_op(6'b001000, 6'b001000); cycle();
    set_idle(); cycle();
    check("isr_zf", eflags, 32'h0000_0043);
    iret = 1; cycle();
    set_idle();
    check("iret_restore", eflags, 32'h0000_0003);
    check("iret_idle", 32'(isr_active), 32'h0);
    isr_entry = 1; cycle();
    isr_entry = 1; cycle();
    set_idle(); cycle(); cycle();
    check("nested_err", 32'(isr_err), 32'h1);
    iret = 1; cycle();
    set_idle(); cycle();
    check("err_sticky", 32'(isr_err), 32'h1);

    // Reset with an entry pending: no commit
    drive_op(6'b111111, 6'b111111); cycle();
    set_idle(); rst = 1; cycle();
    set_idle(); cycle();
    check("rst_mid", eflags, 32'h2);
    check("rst_mid_err", 32'(isr_err), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_idle();
      ex_v       = ($urandom_range(0, 3) != 0);
      alu1_flags = 6'($urandom);
      cmps_flags = 6'($urandom);
      cmps_sel   = 1'($urandom);
      {ld_flag_OF, ld_flag_SF, ld_flag_ZF, ld_flag_AF, ld_flag_PF, ld_flag_CF} = 6'($urandom);
      df_val_ex  = 1'($urandom);
      ld_df      = 1'($urandom);
      popf_v     = ($urandom_range(0, 7) == 0);
      popf_val   = $urandom;
      wb_stall   = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      isr_entry  = ($urandom_range(0, 19) == 0);
      iret       = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
